// File: rtl/cube_usb_pkg.sv
// Shared constants and FSM state types for the cube display USB receive path.
package cube_usb_pkg;

  localparam int HDR_MARKER_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_RECOVER
  } strobe_state_e;

  typedef enum logic {
    PS_HEADER,
    PS_PAYLOAD
  } parse_state_e;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for asynchronous level inputs; resets to RESET_VAL.
module synchronizer #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/usb_rx_chunk_assembler.sv
// FT245-style receive engine: drives the rd_n strobe, parses header-framed row
// packets and emits chunk-word writes with panel/row/chunk addressing.
module usb_rx_chunk_assembler
  import cube_usb_pkg::*;
#(
  parameter int BYTES_PER_CHUNK = 4,
  parameter int CHUNKS_PER_ROW  = 16,
  parameter int ROWS            = 16,
  parameter int PANELS          = 4,
  parameter int RD_LOW_CYCLES   = 3,
  parameter int RD_HIGH_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES  = 65535,
  localparam int CHUNK_W = 8 * BYTES_PER_CHUNK,
  localparam int CA_W    = $clog2(CHUNKS_PER_ROW),
  localparam int RW      = $clog2(ROWS),
  localparam int PW      = $clog2(PANELS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rxf_n_raw,
  input  logic [7:0]         data_bus,
  output logic               rd_n,
  output logic               wr_n,
  output logic [CHUNK_W-1:0] chunk_data,
  output logic [CA_W-1:0]    chunk_data_addr,
  output logic               chunk_data_write_enable,
  output logic [RW-1:0]      row_data_row_addr,
  output logic [PW-1:0]      row_data_panel_addr,
  output logic               row_done,
  output logic [7:0]         error_count
);

  localparam int CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BC_W    = $clog2(BYTES_PER_CHUNK);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(RD_HIGH_CYCLES - 1);
  localparam logic [BC_W-1:0]  BYTE_LAST  = BC_W'(BYTES_PER_CHUNK - 1);
  localparam logic [CA_W-1:0]  CHUNK_LAST = CA_W'(CHUNKS_PER_ROW - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

  generate
    if (RW + PW > 7) begin : g_bad_header_fields
      $error("row and panel fields do not fit below the header marker bit");
    end
    if (RD_LOW_CYCLES < 2 || RD_HIGH_CYCLES < 3 || BYTES_PER_CHUNK < 2) begin : g_bad_timing
      $error("RD_LOW_CYCLES>=2, RD_HIGH_CYCLES>=3 and BYTES_PER_CHUNK>=2 are required");
    end
  endgenerate

  logic rxf_n;

  // Resets to 1 so a freshly reset engine never sees phantom data.
  synchronizer #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rxf_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxf_n_raw),
    .q    (rxf_n)
  );

  // ---------------- strobe FSM ----------------
  strobe_state_e    sstate_q, sstate_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             rd_n_q, rd_n_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sstate_q     <= ST_IDLE;
      scnt_q       <= '0;
      rd_n_q       <= 1'b1;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      sstate_q     <= sstate_d;
      scnt_q       <= scnt_d;
      rd_n_q       <= rd_n_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    sstate_d     = sstate_q;
    scnt_d       = scnt_q;
    rd_n_d       = rd_n_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    unique case (sstate_q)
      ST_IDLE: begin
        if (!rxf_n) begin
          sstate_d = ST_STROBE;
          scnt_d   = '0;
          rd_n_d   = 1'b0;
        end
      end
      ST_STROBE: begin
        // Data is captured on the final low cycle, when the bus has settled longest.
        if (scnt_q == LOW_LAST) begin
          byte_d       = data_bus;
          byte_valid_d = 1'b1;
          rd_n_d       = 1'b1;
          scnt_d       = '0;
          sstate_d     = ST_RECOVER;
        end else begin
          scnt_d = scnt_q + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (scnt_q == HIGH_LAST) begin
          sstate_d = ST_IDLE;
        end else begin
          scnt_d = scnt_q + CNT_W'(1);
        end
      end
      default: begin
        sstate_d = ST_IDLE;
        rd_n_d   = 1'b1;
      end
    endcase
  end

  // ---------------- packet parser ----------------
  parse_state_e       pstate_q, pstate_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [CA_W-1:0]    cidx_q, cidx_d;
  logic [CHUNK_W-9:0] shift_q, shift_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic [CHUNK_W-1:0] chunk_data_q, chunk_data_d;
  logic [CA_W-1:0]    chunk_addr_q, chunk_addr_d;
  logic               chunk_we_q, chunk_we_d;
  logic [RW-1:0]      row_q, row_d;
  logic [PW-1:0]      panel_q, panel_d;
  logic               row_done_q, row_done_d;
  logic [7:0]         err_q, err_d;

  logic               err_inc;
  logic [CHUNK_W-1:0] assembled;
  logic [RW-1:0]      hdr_row;
  logic [PW-1:0]      hdr_panel;
  logic               hdr_ok;

  // Earlier bytes sit above the incoming one, giving big-endian packing.
  assign assembled = {shift_q, byte_q};
  assign hdr_row   = byte_q[RW-1:0];
  assign hdr_panel = byte_q[RW+PW-1:RW];
  assign hdr_ok    = byte_q[HDR_MARKER_BIT] && (int'(hdr_row) < ROWS) && (int'(hdr_panel) < PANELS);

  always_ff @(posedge clk) begin
    if (reset) begin
      pstate_q     <= PS_HEADER;
      bcnt_q       <= '0;
      cidx_q       <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      chunk_data_q <= '0;
      chunk_addr_q <= '0;
      chunk_we_q   <= 1'b0;
      row_q        <= '0;
      panel_q      <= '0;
      row_done_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      pstate_q     <= pstate_d;
      bcnt_q       <= bcnt_d;
      cidx_q       <= cidx_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      chunk_data_q <= chunk_data_d;
      chunk_addr_q <= chunk_addr_d;
      chunk_we_q   <= chunk_we_d;
      row_q        <= row_d;
      panel_q      <= panel_d;
      row_done_q   <= row_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    pstate_d     = pstate_q;
    bcnt_d       = bcnt_q;
    cidx_d       = cidx_q;
    shift_d      = shift_q;
    idle_d       = idle_q;
    chunk_data_d = chunk_data_q;
    chunk_addr_d = chunk_addr_q;
    chunk_we_d   = 1'b0;
    row_d        = row_q;
    panel_d      = panel_q;
    row_done_d   = chunk_we_q && (chunk_addr_q == CHUNK_LAST);
    err_d        = err_q;
    err_inc      = 1'b0;
    unique case (pstate_q)
      PS_HEADER: begin
        if (byte_valid_q) begin
          if (hdr_ok) begin
            row_d    = hdr_row;
            panel_d  = hdr_panel;
            bcnt_d   = '0;
            cidx_d   = '0;
            idle_d   = '0;
            pstate_d = PS_PAYLOAD;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      PS_PAYLOAD: begin
        if (byte_valid_q) begin
          idle_d  = '0;
          shift_d = assembled[CHUNK_W-9:0];
          if (bcnt_q == BYTE_LAST) begin
            bcnt_d       = '0;
            chunk_data_d = assembled;
            chunk_addr_d = cidx_q;
            chunk_we_d   = 1'b1;
            cidx_d       = cidx_q + CA_W'(1);
            if (cidx_q == CHUNK_LAST) begin
              pstate_d = PS_HEADER;
            end
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end else if (idle_q == TO_LIMIT) begin
          // Abandon the stalled row; bytes already assembled are simply dropped.
          err_inc  = 1'b1;
          pstate_d = PS_HEADER;
        end else begin
          idle_d = idle_q + TO_W'(1);
        end
      end
    endcase
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  assign rd_n                    = rd_n_q;
  assign wr_n                    = 1'b1;
  assign chunk_data              = chunk_data_q;
  assign chunk_data_addr         = chunk_addr_q;
  assign chunk_data_write_enable = chunk_we_q;
  assign row_data_row_addr       = row_q;
  assign row_data_panel_addr     = panel_q;
  assign row_done                = row_done_q;
  assign error_count             = err_q;

endmodule

// File: tb/tb_usb_rx_chunk_assembler.sv
// Directed bench: FIFO-chip models feed a default-size engine (A) and a
// reduced-size engine (B); each task checks one scenario against hand values.
module tb_usb_rx_chunk_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine A (default geometry, short timeout) ----------------
  logic        reset_a = 1'b1;
  logic        rxf_a;
  logic [7:0]  data_a;
  logic        rd_n_a, wr_n_a, we_a, row_done_a;
  logic [31:0] chunk_a;
  logic [3:0]  addr_a, row_a;
  logic [1:0]  panel_a;
  logic [7:0]  err_a;

  logic [7:0] fifo_a [0:1023];
  int wp_a = 0;
  int rp_a = 0;
  assign rxf_a  = (rp_a == wp_a);
  assign data_a = fifo_a[rp_a];

  usb_rx_chunk_assembler #(
    .TIMEOUT_CYCLES(100)
  ) dut_a (
    .clk                    (clk),
    .reset                  (reset_a),
    .rxf_n_raw              (rxf_a),
    .data_bus               (data_a),
    .rd_n                   (rd_n_a),
    .wr_n                   (wr_n_a),
    .chunk_data             (chunk_a),
    .chunk_data_addr        (addr_a),
    .chunk_data_write_enable(we_a),
    .row_data_row_addr      (row_a),
    .row_data_panel_addr    (panel_a),
    .row_done               (row_done_a),
    .error_count            (err_a)
  );

  // ---------------- engine B (reduced geometry) ----------------
  logic        reset_b = 1'b1;
  logic        rxf_b;
  logic [7:0]  data_b;
  logic        rd_n_b, wr_n_b, we_b, row_done_b;
  logic [15:0] chunk_b;
  logic [2:0]  addr_b, row_b;
  logic [0:0]  panel_b;
  logic [7:0]  err_b;

  logic [7:0] fifo_b [0:255];
  int wp_b = 0;
  int rp_b = 0;
  assign rxf_b  = (rp_b == wp_b);
  assign data_b = fifo_b[rp_b];

  usb_rx_chunk_assembler #(
    .BYTES_PER_CHUNK(2),
    .CHUNKS_PER_ROW (8),
    .ROWS           (8),
    .PANELS         (2),
    .TIMEOUT_CYCLES (100)
  ) dut_b (
    .clk                    (clk),
    .reset                  (reset_b),
    .rxf_n_raw              (rxf_b),
    .data_bus               (data_b),
    .rd_n                   (rd_n_b),
    .wr_n                   (wr_n_b),
    .chunk_data             (chunk_b),
    .chunk_data_addr        (addr_b),
    .chunk_data_write_enable(we_b),
    .row_data_row_addr      (row_b),
    .row_data_panel_addr    (panel_b),
    .row_done               (row_done_b),
    .error_count            (err_b)
  );

  // ---------------- FIFO pop, strobe shape and write capture ----------------
  logic rd_prev_a = 1'b1;
  logic rd_prev_b = 1'b1;
  int low_run_a = 0, high_run_a = 0, low_bad_a = 0, high_bad_a = 0, pulses_a = 0;

  logic [31:0] log_data_a [0:255];
  logic [3:0]  log_addr_a [0:255];
  logic [3:0]  log_row_a  [0:255];
  logic [1:0]  log_pan_a  [0:255];
  int wcnt_a = 0, rdone_a = 0, last_we_cyc_a = 0, rdone_cyc_a = 0;

  logic [15:0] log_data_b [0:63];
  logic [2:0]  log_addr_b [0:63];
  logic [2:0]  log_row_b  [0:63];
  logic [0:0]  log_pan_b  [0:63];
  int wcnt_b = 0, rdone_b = 0;

  // The chip advances its FIFO on the rising edge of rd_n.
  always @(negedge clk) begin
    rd_prev_a <= rd_n_a;
    if (rd_n_a && !rd_prev_a) begin
      rp_a     <= rp_a + 1;
      pulses_a <= pulses_a + 1;
      if (low_run_a != 3) low_bad_a <= low_bad_a + 1;
    end
    if (!rd_n_a && rd_prev_a && pulses_a > 0 && high_run_a < 3) high_bad_a <= high_bad_a + 1;
    low_run_a  <= rd_n_a ? 0 : low_run_a + 1;
    high_run_a <= rd_n_a ? high_run_a + 1 : 0;
    if (we_a) begin
      log_data_a[wcnt_a] <= chunk_a;
      log_addr_a[wcnt_a] <= addr_a;
      log_row_a[wcnt_a]  <= row_a;
      log_pan_a[wcnt_a]  <= panel_a;
      wcnt_a             <= wcnt_a + 1;
      last_we_cyc_a      <= cyc;
    end
    if (row_done_a) begin
      rdone_a     <= rdone_a + 1;
      rdone_cyc_a <= cyc;
    end
  end

  always @(negedge clk) begin
    rd_prev_b <= rd_n_b;
    if (rd_n_b && !rd_prev_b) rp_b <= rp_b + 1;
    if (we_b) begin
      log_data_b[wcnt_b] <= chunk_b;
      log_addr_b[wcnt_b] <= addr_b;
      log_row_b[wcnt_b]  <= row_b;
      log_pan_b[wcnt_b]  <= panel_b;
      wcnt_b             <= wcnt_b + 1;
    end
    if (row_done_b) rdone_b <= rdone_b + 1;
  end

  task automatic push_a(input logic [7:0] b);
    fifo_a[wp_a] = b;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [7:0] b);
    fifo_b[wp_b] = b;
    wp_b = wp_b + 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (rd_n_a !== 1'b1) $display("FAIL reset_rd_n: got %b expected 1", rd_n_a); else n_pass++;
    n_checks++; if (wr_n_a !== 1'b1) $display("FAIL reset_wr_n: got %b expected 1", wr_n_a); else n_pass++;
    n_checks++; if (chunk_a !== 32'h0 || addr_a !== 4'h0) $display("FAIL reset_chunk: got %h/%0d expected 0/0", chunk_a, addr_a); else n_pass++;
    n_checks++; if (we_a !== 1'b0 || row_done_a !== 1'b0) $display("FAIL reset_pulses: got we=%b done=%b expected 0/0", we_a, row_done_a); else n_pass++;
    n_checks++; if (row_a !== 4'h0 || panel_a !== 2'h0 || err_a !== 8'h0) $display("FAIL reset_addr_err: got row=%0d panel=%0d err=%0d expected 0", row_a, panel_a, err_a); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single_row();
    int w0, r0;
    w0 = wcnt_a;
    r0 = rdone_a;
    push_a(8'h93);
    for (int i = 0; i < 64; i++) push_a(i[7:0]);
    repeat (600) @(negedge clk);
    n_checks++; if (wcnt_a - w0 !== 16) $display("FAIL row_write_count: got %0d expected 16", wcnt_a - w0); else n_pass++;
    n_checks++; if (log_data_a[w0] !== 32'h00010203) $display("FAIL row_first_word: got %h expected 00010203", log_data_a[w0]); else n_pass++;
    n_checks++; if (log_data_a[w0+15] !== 32'h3C3D3E3F) $display("FAIL row_last_word: got %h expected 3c3d3e3f", log_data_a[w0+15]); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (log_addr_a[w0+i] !== i[3:0]) $display("FAIL row_chunk_addr: write %0d got %0d expected %0d", i, log_addr_a[w0+i], i); else n_pass++;
    end
    n_checks++; if (log_row_a[w0] !== 4'd3 || log_pan_a[w0] !== 2'd1) $display("FAIL row_panel_addr: got row=%0d panel=%0d expected 3/1", log_row_a[w0], log_pan_a[w0]); else n_pass++;
    n_checks++; if (rdone_a - r0 !== 1) $display("FAIL row_done_count: got %0d expected 1", rdone_a - r0); else n_pass++;
    n_checks++; if (rdone_cyc_a !== last_we_cyc_a + 1) $display("FAIL row_done_timing: got cycle %0d expected %0d", rdone_cyc_a, last_we_cyc_a + 1); else n_pass++;
    n_checks++; if (err_a !== 8'd0) $display("FAIL row_err: got %0d expected 0", err_a); else n_pass++;
    $display("test_single_row writes=%0d row_done=%0d", wcnt_a - w0, rdone_a - r0);
  endtask

  task automatic test_handshake();
    int lb, hb, p0, w0, lat;
    lb = low_bad_a;
    hb = high_bad_a;
    p0 = pulses_a;
    w0 = wcnt_a;
    push_a(8'h85);
    for (int i = 0; i < 64; i++) push_a(8'hC0 + i[7:0]);
    lat = 0;
    while (rd_n_a && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (rd_n_a !== 1'b0 || lat > 3) $display("FAIL rd_fall_latency: got %0d clocks expected <=3", lat); else n_pass++;
    repeat (600) @(negedge clk);
    n_checks++; if (low_bad_a - lb !== 0) $display("FAIL rd_low_width: got %0d bad pulses expected 0", low_bad_a - lb); else n_pass++;
    n_checks++; if (high_bad_a - hb !== 0) $display("FAIL rd_high_gap: got %0d short gaps expected 0", high_bad_a - hb); else n_pass++;
    n_checks++; if (pulses_a - p0 !== 65) $display("FAIL rd_pulse_count: got %0d expected 65", pulses_a - p0); else n_pass++;
    n_checks++; if (wcnt_a - w0 !== 16 || log_data_a[w0+15] !== 32'hFCFDFEFF) $display("FAIL hs_row: got %0d writes last %h expected 16 fcfdfeff", wcnt_a - w0, log_data_a[w0+15]); else n_pass++;
    n_checks++; if (log_row_a[w0] !== 4'd5 || log_pan_a[w0] !== 2'd0) $display("FAIL hs_addr: got row=%0d panel=%0d expected 5/0", log_row_a[w0], log_pan_a[w0]); else n_pass++;
    $display("test_handshake latency=%0d pulses=%0d", lat, pulses_a - p0);
  endtask

  task automatic test_bad_header();
    int w0, r0;
    w0 = wcnt_a;
    r0 = rdone_a;
    push_a(8'h13);
    push_a(8'h80);
    for (int i = 0; i < 64; i++) push_a(8'h40 + i[7:0]);
    repeat (700) @(negedge clk);
    n_checks++; if (err_a !== 8'd1) $display("FAIL bad_hdr_err: got %0d expected 1", err_a); else n_pass++;
    n_checks++; if (wcnt_a - w0 !== 16) $display("FAIL bad_hdr_writes: got %0d expected 16", wcnt_a - w0); else n_pass++;
    n_checks++; if (log_data_a[w0] !== 32'h40414243) $display("FAIL bad_hdr_word: got %h expected 40414243", log_data_a[w0]); else n_pass++;
    n_checks++; if (log_row_a[w0] !== 4'd0 || log_pan_a[w0] !== 2'd0) $display("FAIL bad_hdr_addr: got row=%0d panel=%0d expected 0/0", log_row_a[w0], log_pan_a[w0]); else n_pass++;
    n_checks++; if (rdone_a - r0 !== 1) $display("FAIL bad_hdr_done: got %0d expected 1", rdone_a - r0); else n_pass++;
    $display("test_bad_header err=%0d writes=%0d", err_a, wcnt_a - w0);
  endtask

  task automatic test_timeout();
    int w0, r0;
    w0 = wcnt_a;
    r0 = rdone_a;
    push_a(8'h86);
    for (int i = 0; i < 10; i++) push_a(8'hB0 + i[7:0]);
    repeat (300) @(negedge clk);
    n_checks++; if (wcnt_a - w0 !== 2) $display("FAIL timeout_writes: got %0d expected 2", wcnt_a - w0); else n_pass++;
    n_checks++; if (log_data_a[w0+1] !== 32'hB4B5B6B7) $display("FAIL timeout_word: got %h expected b4b5b6b7", log_data_a[w0+1]); else n_pass++;
    n_checks++; if (rdone_a - r0 !== 0) $display("FAIL timeout_done: got %0d expected 0", rdone_a - r0); else n_pass++;
    n_checks++; if (err_a !== 8'd2) $display("FAIL timeout_err: got %0d expected 2", err_a); else n_pass++;
    w0 = wcnt_a;
    r0 = rdone_a;
    push_a(8'h95);
    for (int i = 0; i < 64; i++) push_a(i[7:0]);
    repeat (600) @(negedge clk);
    n_checks++; if (wcnt_a - w0 !== 16 || log_data_a[w0] !== 32'h00010203) $display("FAIL after_timeout_row: got %0d writes first %h expected 16 00010203", wcnt_a - w0, log_data_a[w0]); else n_pass++;
    n_checks++; if (log_row_a[w0] !== 4'd5 || log_pan_a[w0] !== 2'd1) $display("FAIL after_timeout_addr: got row=%0d panel=%0d expected 5/1", log_row_a[w0], log_pan_a[w0]); else n_pass++;
    n_checks++; if (rdone_a - r0 !== 1 || err_a !== 8'd2) $display("FAIL after_timeout_done: got done=%0d err=%0d expected 1/2", rdone_a - r0, err_a); else n_pass++;
    $display("test_timeout err=%0d", err_a);
  endtask

  task automatic test_reset_mid_strobe();
    int w0, r0, lat;
    push_a(8'hA1);
    lat = 0;
    while (rd_n_a && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (rd_n_a !== 1'b0) $display("FAIL mid_strobe_start: got rd_n=%b expected 0", rd_n_a); else n_pass++;
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    n_checks++; if (rd_n_a !== 1'b1) $display("FAIL mid_strobe_rd_n: got %b expected 1", rd_n_a); else n_pass++;
    n_checks++; if (err_a !== 8'd0 || row_a !== 4'd0 || panel_a !== 2'd0) $display("FAIL mid_strobe_state: got err=%0d row=%0d panel=%0d expected 0", err_a, row_a, panel_a); else n_pass++;
    n_checks++; if (chunk_a !== 32'h0 || addr_a !== 4'h0 || we_a !== 1'b0 || row_done_a !== 1'b0) $display("FAIL mid_strobe_outputs: got %h/%0d/%b/%b expected 0", chunk_a, addr_a, we_a, row_done_a); else n_pass++;
    w0 = wcnt_a;
    r0 = rdone_a;
    repeat (20) @(negedge clk);
    push_a(8'h92);
    for (int i = 0; i < 64; i++) push_a(8'h20 + i[7:0]);
    repeat (600) @(negedge clk);
    n_checks++; if (wcnt_a - w0 !== 16 || log_data_a[w0] !== 32'h20212223) $display("FAIL post_reset_row: got %0d writes first %h expected 16 20212223", wcnt_a - w0, log_data_a[w0]); else n_pass++;
    n_checks++; if (log_row_a[w0] !== 4'd2 || log_pan_a[w0] !== 2'd1) $display("FAIL post_reset_addr: got row=%0d panel=%0d expected 2/1", log_row_a[w0], log_pan_a[w0]); else n_pass++;
    n_checks++; if (rdone_a - r0 !== 1 || err_a !== 8'd0) $display("FAIL post_reset_done: got done=%0d err=%0d expected 1/0", rdone_a - r0, err_a); else n_pass++;
    $display("test_reset_mid_strobe writes=%0d", wcnt_a - w0);
  endtask

  task automatic test_param_sweep();
    int w0, r0;
    w0 = wcnt_b;
    r0 = rdone_b;
    push_b(8'h8F);
    for (int i = 0; i < 16; i++) push_b(8'h10 + i[7:0]);
    repeat (200) @(negedge clk);
    n_checks++; if (wcnt_b - w0 !== 8) $display("FAIL sweep_writes: got %0d expected 8", wcnt_b - w0); else n_pass++;
    n_checks++; if (log_data_b[w0] !== 16'h1011) $display("FAIL sweep_first: got %h expected 1011", log_data_b[w0]); else n_pass++;
    n_checks++; if (log_data_b[w0+7] !== 16'h1E1F || log_addr_b[w0+7] !== 3'd7) $display("FAIL sweep_last: got %h@%0d expected 1e1f@7", log_data_b[w0+7], log_addr_b[w0+7]); else n_pass++;
    n_checks++; if (log_row_b[w0] !== 3'd7 || log_pan_b[w0] !== 1'b1) $display("FAIL sweep_addr: got row=%0d panel=%0d expected 7/1", log_row_b[w0], log_pan_b[w0]); else n_pass++;
    n_checks++; if (rdone_b - r0 !== 1 || err_b !== 8'd0) $display("FAIL sweep_done: got done=%0d err=%0d expected 1/0", rdone_b - r0, err_b); else n_pass++;
    $display("test_param_sweep writes=%0d", wcnt_b - w0);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_handshake();
    test_bad_header();
    test_timeout();
    test_reset_mid_strobe();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_chunk_assembler.md
# usb_rx_chunk_assembler

Parametrised FT245-style USB receive engine for the cube display path. It runs the `rd_n` strobe handshake against the USB FIFO chip and parses header-framed row packets from the byte stream. It packs payload bytes into chunk words and issues chunk writes with panel/row/chunk addressing into the row buffer. Protocol errors and stalls are detected, counted and resynchronised, with no host intervention.

## Interface
Parameters:
- `BYTES_PER_CHUNK`, 4: bytes per chunk word; `CHUNK_W = 8*BYTES_PER_CHUNK`.
- `CHUNKS_PER_ROW`, 16: chunks per row packet; `CA_W = $clog2(CHUNKS_PER_ROW)`.
- `ROWS`, 16: rows per panel; `RW = $clog2(ROWS)`.
- `PANELS`, 4: panel count; `PW = $clog2(PANELS)`. `RW+PW <= 7` is required (elaboration `$error` otherwise).
- `RD_LOW_CYCLES`, 3: `rd_n` low width in clocks, ≥2.
- `RD_HIGH_CYCLES`, 3: `rd_n` recovery in clocks, ≥3, covering the synchroniser latency on `rxf_n`.
- `TIMEOUT_CYCLES`, 65535: idle clocks allowed between payload bytes.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rxf_n_raw` in 1: FIFO data-available, async, active-low.
- `data_bus` in 8: FIFO data; the bidirectional pad is resolved at top level.
- `rd_n` out 1: read strobe, registered; reset 1.
- `wr_n` out 1: constant 1, because this block is receive-only.
- `chunk_data` out CHUNK_W: assembled word; reset 0.
- `chunk_data_addr` out CA_W: chunk index within row; reset 0.
- `chunk_data_write_enable` out 1: one-cycle write pulse; reset 0.
- `row_data_row_addr` out RW: row from the current header; reset 0.
- `row_data_panel_addr` out PW: panel from the current header; reset 0.
- `row_done` out 1: one-cycle pulse after the last chunk of a row; reset 0.
- `error_count` out 8: saturating protocol-error count; reset 0.

## Operation
- `rxf_n_raw` passes through a 2-flop synchroniser to give `rxf_n`.
- Strobe FSM has three states: IDLE, STROBE, RECOVER.
  - IDLE: when `rxf_n`=0, go to STROBE and drive `rd_n` to 0 (registered).
  - STROBE: hold `rd_n`=0 for RD_LOW_CYCLES. On the last cycle, latch `data_bus` into `byte_q` and pulse `byte_valid`. Then go to RECOVER with `rd_n`=1.
  - RECOVER: hold `rd_n`=1 for RD_HIGH_CYCLES, then go to IDLE.
- Parser FSM has two states: HEADER and PAYLOAD. It acts on `byte_valid`.
  - HEADER: the byte must have bit7=1, row = bits[RW-1:0], panel = bits[RW+PW-1:RW].
  - If row<ROWS and panel<PANELS, latch the row/panel outputs, clear the byte and chunk counters, and go to PAYLOAD.
  - Otherwise drop the byte, increment `error_count`, and stay in HEADER.
  - PAYLOAD: shift the byte in big-endian order, so the first byte lands in `chunk_data[CHUNK_W-1:CHUNK_W-8]`.
  - After BYTES_PER_CHUNK bytes, update `chunk_data` and pulse `chunk_data_write_enable` with `chunk_data_addr` = chunk index, then increment the chunk index.
  - After chunk CHUNKS_PER_ROW-1 is written, pulse `row_done` and go to HEADER.
  - Payload bytes are never interpreted as headers.
- Timeout: in PAYLOAD the idle counter resets on every `byte_valid`. When it reaches TIMEOUT_CYCLES, abandon the row (no partial write, no `row_done`), increment `error_count`, and go to HEADER.
- `error_count` saturates at 255. A header error and a timeout cannot coincide.
- Reset mid-strobe: `rd_n` is 1 on the cycle after reset, and the in-flight byte is discarded. Both FSMs return to IDLE/HEADER and all outputs take their reset values.

## Timing
- `rxf_n_raw` falls → `rd_n` falls within 3 clocks: 2 sync clocks plus the registered output.
- A byte occupies RD_LOW_CYCLES+RD_HIGH_CYCLES+1 clocks. The default is 7 clocks per byte.
- `chunk_data_write_enable` asserts the clock after the final byte of the chunk is latched. `chunk_data` and the addresses are valid that same cycle and held until the next write.
- `row_done` asserts the clock after the last `chunk_data_write_enable`.
- `rxf_n` sampled high in IDLE: no strobe is issued, and the FSM stays in IDLE indefinitely without error.

## Structure
- A shared package `cube_usb_pkg` holds the header bit7 marker constant, the strobe FSM state enum and the parser FSM state enum.
- The existing `synchronizer` module is reused for `rxf_n_raw` with WIDTH=1.
- The strobe FSM and the parser stay in one module, connected by `byte_valid`/`byte_q`.

## Test plan
- Reset, then a single row: header 0x93 plus 64 bytes 0x00..0x3F → 16 writes. Write 0 is `chunk_data`=0x00010203, write 15 is 0x3C3D3E3F. Addresses run 0..15, row=3, panel=1, then one `row_done` pulse.
- Handshake timing: `rxf_n_raw` held low → each `rd_n` low pulse is exactly 3 clocks and each high gap is ≥3 clocks. `rd_n` falls ≤3 clocks after `rxf_n_raw` falls.
- Bad header 0x13 followed by a valid header 0x80 and its row → `error_count`=1, and the row is written to panel 0, row 0.
- Timeout with TIMEOUT_CYCLES=100: stall after 10 payload bytes → 2 writes only, no `row_done`, `error_count`=1. The next header parses normally.
- Reset asserted during STROBE → `rd_n`=1 next cycle, all outputs at reset values, and the next packet assembles correctly.
- Parameter sweep BYTES_PER_CHUNK=2, CHUNKS_PER_ROW=8, ROWS=8, PANELS=2 → 8 writes per row, `chunk_data` 16 bits, header 0x8F gives row 7, panel 1.
